// File: rtl/roce_pkg.sv
// Shared definitions for the RoCE traffic generator: op codes, meta field
// layout and the command FSM state encoding.
package roce_pkg;

  localparam logic [2:0] ROCE_OP_READ  = 3'd0;
  localparam logic [2:0] ROCE_OP_WRITE = 3'd1;

  localparam int META_OP_LSB    = 0;
  localparam int META_OP_W      = 3;
  localparam int META_QPN_LSB   = 3;
  localparam int META_QPN_W     = 24;
  localparam int META_LADDR_LSB = 27;
  localparam int META_RADDR_LSB = 75;
  localparam int META_ADDR_W    = 48;
  localparam int META_LEN_LSB   = 123;
  localparam int META_LEN_W     = 32;
  localparam int META_FIELDS_W  = 155;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_META,
    ST_DATA,
    ST_DRAIN
  } roce_state_e;

  function automatic logic [META_FIELDS_W-1:0] roce_pack_meta(
    input logic [META_OP_W-1:0]   op,
    input logic [META_QPN_W-1:0]  qpn,
    input logic [META_ADDR_W-1:0] laddr,
    input logic [META_ADDR_W-1:0] raddr,
    input logic [META_LEN_W-1:0]  len
  );
    logic [META_FIELDS_W-1:0] m;
    m = '0;
    m[META_OP_LSB    +: META_OP_W]   = op;
    m[META_QPN_LSB   +: META_QPN_W]  = qpn;
    m[META_LADDR_LSB +: META_ADDR_W] = laddr;
    m[META_RADDR_LSB +: META_ADDR_W] = raddr;
    m[META_LEN_LSB   +: META_LEN_W]  = len;
    return m;
  endfunction

endpackage

// File: rtl/roce_data_pattern_gen.sv
// WRITE payload sequencing: global beat counter, beats per burst derived from
// the transfer length, and end-of-burst flag.
module roce_data_pattern_gen #(
  parameter int DATA_W = 512
) (
  input  logic        ap_clk,
  input  logic        areset,
  input  logic        clear,
  input  logic [4:0]  log2_len,
  input  logic        beat_fire,
  output logic [31:0] beat_cnt,
  output logic        burst_last
);

  localparam logic [4:0] LOG2_BPB = 5'($clog2(DATA_W / 8));

  logic [31:0] burst_idx;
  logic [31:0] beats_m1;

  // Transfers shorter than one bus word still take a single beat.
  always_comb begin
    beats_m1 = '0;
    if (log2_len > LOG2_BPB)
      beats_m1 = (32'd1 << (log2_len - LOG2_BPB)) - 32'd1;
  end

  assign burst_last = (burst_idx == beats_m1);

  always_ff @(posedge ap_clk) begin
    if (areset || clear) begin
      beat_cnt  <= '0;
      burst_idx <= '0;
    end else if (beat_fire) begin
      beat_cnt  <= beat_cnt + 32'd1;
      burst_idx <= burst_last ? '0 : burst_idx + 32'd1;
    end
  end

endmodule

// File: rtl/roce_traffic_gen.sv
// RDMA READ/WRITE command generator: round-robin QPs, windowed by retired
// status beats, with WRITE payload sourced from a beat counter pattern.
module roce_traffic_gen
  import roce_pkg::*;
#(
  parameter int META_W          = 256,
  parameter int DATA_W          = 512,
  parameter int STATUS_W        = 512,
  parameter int NUM_QP          = 4,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                         ap_clk,
  input  logic                         areset,
  input  logic                         start,
  input  logic                         cfg_write,
  input  logic [23:0]                  cfg_qpn_base,
  input  logic [$clog2(NUM_QP+1)-1:0]  cfg_num_qp,
  input  logic [4:0]                   cfg_log2_len,
  input  logic [31:0]                  cfg_num_cmds,
  input  logic [47:0]                  cfg_laddr_base,
  input  logic [47:0]                  cfg_raddr_base,
  output logic                         m_axis_tx_meta_tvalid,
  input  logic                         m_axis_tx_meta_tready,
  output logic [META_W-1:0]            m_axis_tx_meta_tdata,
  output logic [META_W/8-1:0]          m_axis_tx_meta_tkeep,
  output logic                         m_axis_tx_meta_tlast,
  output logic                         m_axis_tx_data_tvalid,
  input  logic                         m_axis_tx_data_tready,
  output logic [DATA_W-1:0]            m_axis_tx_data_tdata,
  output logic [DATA_W/8-1:0]          m_axis_tx_data_tkeep,
  output logic                         m_axis_tx_data_tlast,
  input  logic                         s_axis_tx_status_tvalid,
  output logic                         s_axis_tx_status_tready,
  input  logic [STATUS_W-1:0]          s_axis_tx_status_tdata,
  input  logic [STATUS_W/8-1:0]        s_axis_tx_status_tkeep,
  input  logic                         s_axis_tx_status_tlast,
  output logic                         busy,
  output logic                         done,
  output logic                         err_status,
  output logic [31:0]                  issued_cnt,
  output logic [31:0]                  retired_cnt
);

  localparam int QP_W  = $clog2(NUM_QP + 1);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  roce_state_e        state, state_nxt;
  logic               write_q;
  logic [23:0]        qpn_base_q;
  logic [QP_W-1:0]    num_qp_q, num_qp_eff, qp_idx;
  logic [4:0]         log2_len_q;
  logic [31:0]        num_cmds_q, len_bytes, beat_cnt;
  logic [47:0]        laddr_q, raddr_q;
  logic [OUT_W-1:0]   outstanding;
  logic               start_ok, meta_fire, data_fire, status_fire, status_ok;
  logic               burst_last;
  logic               status_unused;

  assign status_unused = ^{s_axis_tx_status_tdata, s_axis_tx_status_tkeep, s_axis_tx_status_tlast};

  assign start_ok    = start && (state == ST_IDLE);
  assign meta_fire   = m_axis_tx_meta_tvalid && m_axis_tx_meta_tready;
  assign data_fire   = m_axis_tx_data_tvalid && m_axis_tx_data_tready;
  assign status_fire = s_axis_tx_status_tvalid;
  assign status_ok   = status_fire && (outstanding != '0);
  assign len_bytes   = 32'd1 << log2_len_q;

  always_comb begin
    num_qp_eff = cfg_num_qp;
    if (cfg_num_qp == '0)
      num_qp_eff = QP_W'(1);
    else if (cfg_num_qp > QP_W'(NUM_QP))
      num_qp_eff = QP_W'(NUM_QP);
  end

  always_ff @(posedge ap_clk) begin
    if (areset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:
        if (start_ok)
          state_nxt = (cfg_num_cmds == '0) ? ST_DRAIN : ST_META;
      ST_META:
        if (meta_fire) begin
          if (write_q)
            state_nxt = ST_DATA;
          else if (issued_cnt + 32'd1 == num_cmds_q)
            state_nxt = ST_DRAIN;
        end
      ST_DATA:
        if (data_fire && burst_last)
          state_nxt = (issued_cnt == num_cmds_q) ? ST_DRAIN : ST_META;
      ST_DRAIN:
        if (retired_cnt == num_cmds_q)
          state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    m_axis_tx_meta_tvalid = (state == ST_META) && (outstanding < OUT_W'(MAX_OUTSTANDING));
    m_axis_tx_data_tvalid = (state == ST_DATA);
    done                  = (state == ST_DRAIN) && (retired_cnt == num_cmds_q);
    busy                  = (state != ST_IDLE) && !done;
  end

  // Command context: latched at start, advanced on each meta handshake.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      write_q     <= 1'b0;
      qpn_base_q  <= '0;
      num_qp_q    <= QP_W'(1);
      log2_len_q  <= '0;
      num_cmds_q  <= '0;
      laddr_q     <= '0;
      raddr_q     <= '0;
      qp_idx      <= '0;
      issued_cnt  <= '0;
      retired_cnt <= '0;
    end else if (start_ok) begin
      write_q     <= cfg_write;
      qpn_base_q  <= cfg_qpn_base;
      num_qp_q    <= num_qp_eff;
      log2_len_q  <= cfg_log2_len;
      num_cmds_q  <= cfg_num_cmds;
      laddr_q     <= cfg_laddr_base;
      raddr_q     <= cfg_raddr_base;
      qp_idx      <= '0;
      issued_cnt  <= '0;
      retired_cnt <= '0;
    end else begin
      if (meta_fire) begin
        issued_cnt <= issued_cnt + 32'd1;
        laddr_q    <= laddr_q + 48'(len_bytes);
        raddr_q    <= raddr_q + 48'(len_bytes);
        qp_idx     <= (qp_idx == num_qp_q - QP_W'(1)) ? '0 : qp_idx + QP_W'(1);
      end
      if (status_ok)
        retired_cnt <= retired_cnt + 32'd1;
    end
  end

  // Window tracking; a status beat with nothing in flight is flagged, not counted.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      outstanding <= '0;
      err_status  <= 1'b0;
    end else begin
      if (meta_fire && !status_ok)
        outstanding <= outstanding + OUT_W'(1);
      else if (!meta_fire && status_ok)
        outstanding <= outstanding - OUT_W'(1);
      if (status_fire && (outstanding == '0))
        err_status <= 1'b1;
    end
  end

  roce_data_pattern_gen #(
    .DATA_W(DATA_W)
  ) u_pattern (
    .ap_clk    (ap_clk),
    .areset    (areset),
    .clear     (start_ok),
    .log2_len  (log2_len_q),
    .beat_fire (data_fire),
    .beat_cnt  (beat_cnt),
    .burst_last(burst_last)
  );

  assign m_axis_tx_meta_tdata = m_axis_tx_meta_tvalid
    ? META_W'(roce_pack_meta(write_q ? ROCE_OP_WRITE : ROCE_OP_READ,
                             qpn_base_q + 24'(qp_idx), laddr_q, raddr_q, len_bytes))
    : '0;
  assign m_axis_tx_meta_tkeep    = '1;
  assign m_axis_tx_meta_tlast    = 1'b1;

  assign m_axis_tx_data_tdata    = m_axis_tx_data_tvalid ? {(DATA_W/32){beat_cnt}} : '0;
  assign m_axis_tx_data_tkeep    = '1;
  assign m_axis_tx_data_tlast    = m_axis_tx_data_tvalid && burst_last;

  assign s_axis_tx_status_tready = 1'b1;

endmodule

// File: tb/tb_roce_traffic_gen.sv
// Directed bench for roce_traffic_gen: READ/WRITE sequencing, window stall,
// backpressure stability, zero-length run, address wrap and reset abort.
module tb_roce_traffic_gen;

  localparam int META_W   = 256;
  localparam int DATA_W   = 512;
  localparam int STATUS_W = 512;
  localparam int NUM_QP   = 4;
  localparam int MAX_OUT  = 2;

  logic                 ap_clk = 1'b0;
  logic                 areset, start, cfg_write;
  logic [23:0]          cfg_qpn_base;
  logic [2:0]           cfg_num_qp;
  logic [4:0]           cfg_log2_len;
  logic [31:0]          cfg_num_cmds;
  logic [47:0]          cfg_laddr_base, cfg_raddr_base;
  logic                 meta_tvalid, meta_tready, meta_tlast;
  logic [META_W-1:0]    meta_tdata;
  logic [META_W/8-1:0]  meta_tkeep;
  logic                 data_tvalid, data_tready, data_tlast;
  logic [DATA_W-1:0]    data_tdata;
  logic [DATA_W/8-1:0]  data_tkeep;
  logic                 st_tvalid, st_tready, st_tlast;
  logic [STATUS_W-1:0]  st_tdata;
  logic [STATUS_W/8-1:0] st_tkeep;
  logic                 busy, done, err_status;
  logic [31:0]          issued_cnt, retired_cnt;

  roce_traffic_gen #(
    .META_W(META_W), .DATA_W(DATA_W), .STATUS_W(STATUS_W),
    .NUM_QP(NUM_QP), .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .ap_clk(ap_clk), .areset(areset), .start(start), .cfg_write(cfg_write),
    .cfg_qpn_base(cfg_qpn_base), .cfg_num_qp(cfg_num_qp), .cfg_log2_len(cfg_log2_len),
    .cfg_num_cmds(cfg_num_cmds), .cfg_laddr_base(cfg_laddr_base), .cfg_raddr_base(cfg_raddr_base),
    .m_axis_tx_meta_tvalid(meta_tvalid), .m_axis_tx_meta_tready(meta_tready),
    .m_axis_tx_meta_tdata(meta_tdata), .m_axis_tx_meta_tkeep(meta_tkeep),
    .m_axis_tx_meta_tlast(meta_tlast),
    .m_axis_tx_data_tvalid(data_tvalid), .m_axis_tx_data_tready(data_tready),
    .m_axis_tx_data_tdata(data_tdata), .m_axis_tx_data_tkeep(data_tkeep),
    .m_axis_tx_data_tlast(data_tlast),
    .s_axis_tx_status_tvalid(st_tvalid), .s_axis_tx_status_tready(st_tready),
    .s_axis_tx_status_tdata(st_tdata), .s_axis_tx_status_tkeep(st_tkeep),
    .s_axis_tx_status_tlast(st_tlast),
    .busy(busy), .done(done), .err_status(err_status),
    .issued_cnt(issued_cnt), .retired_cnt(retired_cnt)
  );

  always #5 ap_clk = ~ap_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int tokens   = 0;
  bit auto_st  = 1'b0;
  bit bp_en    = 1'b0;
  int start_cyc, done_cyc, last_st_cyc;

  logic [META_W-1:0] meta_q[$];
  int                meta_cyc_q[$];
  logic [63:0]       data_q[$];
  bit                data_last_q[$];
  int                data_cyc_q[$];

  bit                meta_hold, data_hold;
  logic [META_W-1:0] meta_held;
  logic [DATA_W-1:0] data_held;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] f_op(input logic [META_W-1:0] m);    return 64'(m[2:0]);     endfunction
  function automatic logic [63:0] f_qpn(input logic [META_W-1:0] m);   return 64'(m[26:3]);    endfunction
  function automatic logic [63:0] f_laddr(input logic [META_W-1:0] m); return 64'(m[74:27]);   endfunction
  function automatic logic [63:0] f_raddr(input logic [META_W-1:0] m); return 64'(m[122:75]);  endfunction
  function automatic logic [63:0] f_len(input logic [META_W-1:0] m);   return 64'(m[154:123]); endfunction

  always @(posedge ap_clk) cyc++;

  // Observation point is the falling edge: a valid/ready pair seen here completes at the next rise.
  always @(negedge ap_clk) begin
    if (meta_hold) begin
      check("meta_hold_vld", 64'(meta_tvalid), 64'd1);
      check("meta_hold_data", 64'(meta_tdata === meta_held), 64'd1);
    end
    if (data_hold) begin
      check("data_hold_vld", 64'(data_tvalid), 64'd1);
      check("data_hold_data", 64'(data_tdata === data_held), 64'd1);
    end
    meta_hold = meta_tvalid && !meta_tready && !areset;
    meta_held = meta_tdata;
    data_hold = data_tvalid && !data_tready && !areset;
    data_held = data_tdata;
    if (meta_tvalid && meta_tready) begin
      meta_q.push_back(meta_tdata);
      meta_cyc_q.push_back(cyc);
      if (auto_st) tokens = tokens + 1;
    end
    if (data_tvalid && data_tready) begin
      data_q.push_back(data_tdata[63:0]);
      data_last_q.push_back(data_tlast);
      data_cyc_q.push_back(cyc);
    end
    if (st_tvalid && st_tready) last_st_cyc = cyc;
    if (done) done_cyc = cyc;
  end

  initial begin
    st_tvalid = 1'b0;
    forever begin
      @(posedge ap_clk); #1;
      if (tokens > 0) begin
        st_tvalid = 1'b1;
        tokens = tokens - 1;
      end else begin
        st_tvalid = 1'b0;
      end
    end
  end

  initial begin
    meta_tready = 1'b1;
    data_tready = 1'b1;
    forever begin
      @(posedge ap_clk); #1;
      meta_tready = bp_en ? ($urandom_range(0, 1) == 1) : 1'b1;
      data_tready = bp_en ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  task automatic clear_logs();
    meta_q.delete(); meta_cyc_q.delete();
    data_q.delete(); data_last_q.delete(); data_cyc_q.delete();
    done_cyc = -1; last_st_cyc = -1;
  endtask

  task automatic start_cmd(input bit wr, input logic [23:0] qpn, input logic [2:0] nqp,
                           input logic [4:0] l2, input logic [31:0] ncmd,
                           input logic [47:0] la, input logic [47:0] ra);
    cfg_write = wr; cfg_qpn_base = qpn; cfg_num_qp = nqp; cfg_log2_len = l2;
    cfg_num_cmds = ncmd; cfg_laddr_base = la; cfg_raddr_base = ra;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge ap_clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge ap_clk);
      seen = done;
      n++;
    end
    check(tag, 64'(seen), 64'd1);
    @(posedge ap_clk); #1;
  endtask

  initial begin
    logic [META_W-1:0] m;
    int n;
    areset = 1'b1; start = 1'b0; cfg_write = 1'b0; cfg_qpn_base = '0; cfg_num_qp = '0;
    cfg_log2_len = '0; cfg_num_cmds = '0; cfg_laddr_base = '0; cfg_raddr_base = '0;
    st_tdata = '0; st_tkeep = '1; st_tlast = 1'b1;
    clear_logs();
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    check("rst_meta_vld", 64'(meta_tvalid), 0);
    check("rst_data_vld", 64'(data_tvalid), 0);
    check("rst_meta_data", 64'(meta_tdata == '0), 1);
    check("rst_data_data", 64'(data_tdata == '0), 1);
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_err", 64'(err_status), 0);
    check("rst_issued", 64'(issued_cnt), 0);
    check("rst_retired", 64'(retired_cnt), 0);
    check("rst_st_tready", 64'(st_tready), 1);
    @(posedge ap_clk); #1;
    areset = 1'b0;
    @(posedge ap_clk); #1;

    // READ over 3 QPs, window-limited but fed immediately
    clear_logs(); auto_st = 1'b1;
    start_cmd(1'b0, 24'h10, 3'd3, 5'd12, 32'd6, 48'h1000_0000, 48'h2000_0000);
    wait_done("rd_done", 200);
    check("rd_nmeta", 64'(meta_q.size()), 6);
    for (int i = 0; i < 6 && i < meta_q.size(); i++) begin
      m = meta_q[i];
      check($sformatf("rd_op%0d", i), f_op(m), 0);
      check($sformatf("rd_qpn%0d", i), f_qpn(m), 64'(24'h10 + 24'(i % 3)));
      check($sformatf("rd_laddr%0d", i), f_laddr(m), 64'h1000_0000 + 64'(4096 * i));
      check($sformatf("rd_raddr%0d", i), f_raddr(m), 64'h2000_0000 + 64'(4096 * i));
      check($sformatf("rd_len%0d", i), f_len(m), 64'd4096);
      check($sformatf("rd_pad%0d", i), 64'(m[META_W-1:155] == '0), 1);
      check($sformatf("rd_cyc%0d", i), 64'(meta_cyc_q[i]), 64'(start_cyc + 1 + i));
    end
    check("rd_issued", 64'(issued_cnt), 6);
    check("rd_retired", 64'(retired_cnt), 6);
    check("rd_done_lat", 64'(done_cyc), 64'(last_st_cyc + 1));
    check("rd_busy_after", 64'(busy), 0);
    check("rd_err", 64'(err_status), 0);

    // WRITE, 256-byte bursts on a 64-byte bus
    clear_logs();
    start_cmd(1'b1, 24'h100, 3'd1, 5'd8, 32'd2, 48'h0, 48'h8000);
    wait_done("wr_done", 200);
    check("wr_nmeta", 64'(meta_q.size()), 2);
    check("wr_ndata", 64'(data_q.size()), 8);
    for (int i = 0; i < 2 && i < meta_q.size(); i++) begin
      check($sformatf("wr_op%0d", i), f_op(meta_q[i]), 1);
      check($sformatf("wr_qpn%0d", i), f_qpn(meta_q[i]), 64'h100);
      check($sformatf("wr_laddr%0d", i), f_laddr(meta_q[i]), 64'(256 * i));
      check($sformatf("wr_raddr%0d", i), f_raddr(meta_q[i]), 64'h8000 + 64'(256 * i));
    end
    for (int i = 0; i < 8 && i < data_q.size(); i++) begin
      check($sformatf("wr_beat%0d", i), data_q[i], {32'(i), 32'(i)});
      check($sformatf("wr_last%0d", i), 64'(data_last_q[i]), 64'((i % 4) == 3));
    end
    if (meta_q.size() == 2 && data_q.size() == 8) begin
      check("wr_data_lat0", 64'(data_cyc_q[0]), 64'(meta_cyc_q[0] + 1));
      check("wr_data_lat1", 64'(data_cyc_q[4]), 64'(meta_cyc_q[1] + 1));
    end

    // Window of 2 with status withheld
    clear_logs(); auto_st = 1'b0;
    start_cmd(1'b0, 24'h20, 3'd2, 5'd6, 32'd3, 48'h0, 48'h0);
    repeat (10) @(posedge ap_clk);
    check("win_stall", 64'(meta_q.size()), 2);
    check("win_issued", 64'(issued_cnt), 2);
    check("win_busy", 64'(busy), 1);
    @(negedge ap_clk); tokens = 1;
    repeat (10) @(posedge ap_clk);
    check("win_one_more", 64'(meta_q.size()), 3);
    @(negedge ap_clk); tokens = 2;
    wait_done("win_done", 50);
    check("win_retired", 64'(retired_cnt), 3);

    // WRITE under random backpressure on both streams
    clear_logs(); auto_st = 1'b1; bp_en = 1'b1;
    start_cmd(1'b1, 24'h30, 3'd4, 5'd7, 32'd3, 48'h100, 48'h200);
    wait_done("bp_done", 500);
    bp_en = 1'b0;
    check("bp_nmeta", 64'(meta_q.size()), 3);
    check("bp_ndata", 64'(data_q.size()), 6);
    for (int i = 0; i < 3 && i < meta_q.size(); i++) begin
      check($sformatf("bp_qpn%0d", i), f_qpn(meta_q[i]), 64'(24'h30 + 24'(i)));
      check($sformatf("bp_laddr%0d", i), f_laddr(meta_q[i]), 64'h100 + 64'(128 * i));
    end
    for (int i = 0; i < 6 && i < data_q.size(); i++) begin
      check($sformatf("bp_beat%0d", i), data_q[i], {32'(i), 32'(i)});
      check($sformatf("bp_last%0d", i), 64'(data_last_q[i]), 64'((i % 2) == 1));
    end
    @(posedge ap_clk); #1;

    // Zero commands: done right after start, no traffic
    clear_logs();
    start_cmd(1'b1, 24'h0, 3'd1, 5'd8, 32'd0, 48'h0, 48'h0);
    @(negedge ap_clk);
    check("zero_done", 64'(done), 1);
    check("zero_busy", 64'(busy), 0);
    check("zero_meta_vld", 64'(meta_tvalid), 0);
    @(negedge ap_clk);
    check("zero_done_pulse", 64'(done), 0);
    check("zero_nmeta", 64'(meta_q.size()), 0);
    @(posedge ap_clk); #1;

    // 48-bit address wrap
    clear_logs();
    start_cmd(1'b0, 24'h0, 3'd1, 5'd12, 32'd2, 48'hFFFF_FFFF_F000, 48'h0);
    wait_done("wrap_done", 100);
    check("wrap_nmeta", 64'(meta_q.size()), 2);
    if (meta_q.size() == 2) begin
      check("wrap_laddr0", f_laddr(meta_q[0]), 64'hFFFF_FFFF_F000);
      check("wrap_laddr1", f_laddr(meta_q[1]), 64'h0);
    end

    // Spurious status while idle
    auto_st = 1'b0;
    check("spur_err_before", 64'(err_status), 0);
    @(negedge ap_clk); tokens = 1;
    repeat (3) @(posedge ap_clk); #1;
    check("spur_err", 64'(err_status), 1);

    // Reset in the middle of a WRITE burst
    clear_logs(); auto_st = 1'b1;
    start_cmd(1'b1, 24'h40, 3'd1, 5'd10, 32'd2, 48'h0, 48'h0);
    n = 0;
    while (data_q.size() < 3 && n < 100) begin
      @(negedge ap_clk);
      n++;
    end
    check("ar_burst_seen", 64'(data_q.size() >= 3), 1);
    auto_st = 1'b0;
    @(posedge ap_clk); #1;
    areset = 1'b1;
    @(posedge ap_clk); #1;
    areset = 1'b0;
    @(negedge ap_clk);
    check("ar_meta_vld", 64'(meta_tvalid), 0);
    check("ar_data_vld", 64'(data_tvalid), 0);
    check("ar_data_data", 64'(data_tdata == '0), 1);
    check("ar_data_last", 64'(data_tlast), 0);
    check("ar_busy", 64'(busy), 0);
    check("ar_done", 64'(done), 0);
    check("ar_err", 64'(err_status), 0);
    check("ar_issued", 64'(issued_cnt), 0);
    check("ar_retired", 64'(retired_cnt), 0);
    tokens = 1;
    repeat (3) @(posedge ap_clk); #1;
    check("ar_late_status_err", 64'(err_status), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
